// File: rtl/control_fsm.sv
// Multi-cycle control FSM for a small RV64I subset (add, sub, addi, ld, sd).
// Optional retired-instruction counter enabled by macro CONTROL_FSM_INSTRET_EN.
`timescale 1ns/1ps
module control_fsm (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] immediate,
  output logic        sub,
  output logic        WE_RF,
  output logic        WE_MEM,
  output logic        RF_din_sel,
  output logic        ULA_din2_sel,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    RST_ST, FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  state_t      state, state_next;
  logic [31:0] ir;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_rtype, is_add, is_sub, is_addi, is_ld, is_sd, legal;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign is_rtype = (opcode == 7'b0110011) && (funct3 == 3'b000);
  assign is_add   = is_rtype && (funct7 == 7'b0000000);
  assign is_sub   = is_rtype && (funct7 == 7'b0100000);
  assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_ld    = (opcode == 7'b0000011) && (funct3 == 3'b011);
  assign is_sd    = (opcode == 7'b0100011) && (funct3 == 3'b011);
  assign legal    = is_add || is_sub || is_addi || is_ld || is_sd;

  // Decoded fields come from the latched IR so they stay stable while instr moves with PC.
  assign rs1          = ir[19:15];
  assign rs2          = ir[24:20];
  assign rd           = ir[11:7];
  assign immediate    = (opcode == 7'b0100011) ? {ir[31:25], ir[11:7]} : ir[31:20];
  assign sub          = is_sub;
  assign ULA_din2_sel = is_addi || is_ld || is_sd;
  assign RF_din_sel   = is_ld;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= RST_ST;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH)
        ir <= instr;
      if (state == DECODE && !legal)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    WE_RF      = 1'b0;
    WE_MEM     = 1'b0;
    case (state)
      RST_ST: begin
        reset_pc   = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        load_pc    = 1'b1;
        state_next = DECODE;
      end
      DECODE:  state_next = legal ? EXEC : TRAP;
      EXEC:    state_next = (is_ld || is_sd) ? MEM : WB;
      MEM: begin
        if (mem_ready) begin
          if (is_sd) begin
            WE_MEM     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        WE_RF      = (rd != 5'd0);
        state_next = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = RST_ST;
    endcase
  end

`ifdef CONTROL_FSM_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state == WB) || (state == MEM && is_sd && mem_ready);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      instret_q <= '0;
    else if (retire)
      instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction expected timeline derived from
// instruction class and stall count, plus hand-computed field literals.
`timescale 1ns/1ps
module tb_control_fsm;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] instr;
  logic        mem_ready;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] immediate;
  logic        sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel;
  logic        load_pc, reset_pc, illegal;
  logic [31:0] instret;

  int vectors     = 0;
  int miscompares = 0;
  int unsigned exp_instret = 0;

  control_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .instr(instr), .mem_ready(mem_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
    .sub(sub), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
    .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc), .reset_pc(reset_pc),
    .illegal(illegal), .instret(instret)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // 0 illegal, 1 add, 2 sub, 3 addi, 4 ld, 5 sd
  function automatic int kind_of(input logic [31:0] w);
    case ({w[31:25], w[14:12], w[6:0]})
      {7'b0000000, 3'b000, 7'b0110011}: return 1;
      {7'b0100000, 3'b000, 7'b0110011}: return 2;
      default: begin
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) return 3;
        if (w[6:0] == 7'b0000011 && w[14:12] == 3'b011) return 4;
        if (w[6:0] == 7'b0100011 && w[14:12] == 3'b011) return 5;
        return 0;
      end
    endcase
  endfunction

  task automatic do_reset_release();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rst_release_reset_pc", reset_pc, 1);
    chk("rst_release_load_pc", load_pc, 0);
  endtask

  // One legal instruction starting at its FETCH cycle; mem_ready low for `stall` MEM cycles.
  task automatic run_instr(input logic [31:0] w, input int stall,
                           input logic [11:0] lit_imm, input logic [4:0] lit_rd);
    int  k;
    int  lat;
    bit  wr_rf;
    bit  is_s;
    k     = kind_of(w);
    is_s  = (k == 5);
    wr_rf = (k >= 1 && k <= 4);
    lat   = (k == 4) ? 5 + stall : (k == 5) ? 4 + stall : 4;
    for (int c = 0; c < lat; c++) begin
      @(negedge CLK);
      instr     = (c == 0) ? w : ~w;
      mem_ready = !((k >= 4) && c >= 3 && c < 3 + stall);
      #1;
      chk("load_pc", load_pc, c == 0);
      chk("reset_pc", reset_pc, 0);
      chk("we_rf", WE_RF, wr_rf && c == lat - 1 && w[11:7] != 5'd0);
      chk("we_mem", WE_MEM, is_s && c == lat - 1);
      chk("illegal", illegal, 0);
      chk("instret", instret, exp_instret);
      if (c >= 1) begin
        chk("rs1", rs1, w[19:15]);
        chk("rs2", rs2, w[24:20]);
        chk("rd", rd, w[11:7]);
        chk("immediate", immediate, is_s ? {w[31:25], w[11:7]} : w[31:20]);
        chk("sub", sub, k == 2);
        chk("ula_din2_sel", ULA_din2_sel, k >= 3);
      end
      if (c == 1) begin
        chk("lit_immediate", immediate, lit_imm);
        chk("lit_rd", rd, lit_rd);
      end
      if (wr_rf && c == lat - 1)
        chk("rf_din_sel", RF_din_sel, k == 4);
    end
`ifdef CONTROL_FSM_INSTRET_EN
    exp_instret++;
`endif
  endtask

  // Illegal instruction: FETCH, DECODE, then TRAP until an asynchronous reset pulse.
  task automatic run_trap(input logic [31:0] w);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      instr     = (c == 0) ? w : 32'h00500093;
      mem_ready = 1'b1;
      #1;
      chk("trap_load_pc", load_pc, c == 0);
      chk("trap_we_rf", WE_RF, 0);
      chk("trap_we_mem", WE_MEM, 0);
      chk("trap_reset_pc", reset_pc, 0);
      chk("trap_illegal", illegal, c >= 2);
      chk("trap_instret", instret, exp_instret);
    end
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    exp_instret = 0;
    chk("async_rst_illegal", illegal, 0);
    chk("async_rst_reset_pc", reset_pc, 1);
    chk("async_rst_load_pc", load_pc, 0);
    chk("async_rst_instret", instret, 0);
    chk("async_rst_rd", rd, 0);
    chk("async_rst_immediate", immediate, 0);
    do_reset_release();
  endtask

  initial begin
    RST_N     = 1'b0;
    instr     = '0;
    mem_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_reset_pc", reset_pc, 1);
    chk("reset_load_pc", load_pc, 0);
    chk("reset_we_rf", WE_RF, 0);
    chk("reset_we_mem", WE_MEM, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_instret", instret, 0);
    chk("reset_immediate", immediate, 0);
    chk("reset_ula_din2_sel", ULA_din2_sel, 0);
    do_reset_release();

    run_instr(32'h00500093, 0, 12'h005, 5'd1);  // addi x1,x0,5
    run_instr(32'h402081B3, 0, 12'h402, 5'd3);  // sub x3,x1,x2
    run_instr(32'h002081B3, 0, 12'h002, 5'd3);  // add x3,x1,x2
`ifdef CONTROL_FSM_INSTRET_EN
    @(posedge CLK);
    #1;
    chk("instret_after_three", instret, 3);
`endif
    run_instr(32'h0020B423, 3, 12'h008, 5'd8);  // sd x2,8(x1), 3 stall cycles
    run_instr(32'h0100B283, 0, 12'h010, 5'd5);  // ld x5,16(x1)
    run_instr(32'h0100B283, 2, 12'h010, 5'd5);  // ld with 2 stall cycles
    run_instr(32'h00100013, 0, 12'h001, 5'd0);  // addi x0,x0,1
    run_instr(32'h0020B423, 0, 12'h008, 5'd8);  // sd, no stall

    run_trap(32'hFFFFFFFF);
    run_instr(32'h00500093, 0, 12'h005, 5'd1);
    run_trap(32'h022081B3);                     // R-type with unsupported funct7
    run_instr(32'h0100B283, 1, 12'h010, 5'd5);
    run_trap(32'h0100A283);                     // ld opcode with funct3 010

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
